// File: rtl/pmod_da_spi_transmitter.sv
// SPI master transmitter for a 16-bit serial DAC frame: takes a word on a valid/ready
// handshake and shifts it out MSB first on sdi, framed by active-low cs, sck idling high.
module pmod_da_spi_transmitter #(
    parameter int SCK_HALF   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [15:0] value,
    output logic        ready,
    output logic        cs,
    output logic        sck,
    output logic        sdi,
    output logic        done
);

    localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_half;
    logic          r_phase;
    logic [3:0]    r_bit;
    logic [GW-1:0] r_gap;
    logic [15:0]   r_shift;
    logic          r_ready;
    logic          r_cs;
    logic          r_sck;
    logic          r_sdi;
    logic          r_done;

    state_t        w_state_next;
    logic [HW-1:0] w_half_next;
    logic          w_phase_next;
    logic [3:0]    w_bit_next;
    logic [GW-1:0] w_gap_next;
    logic [15:0]   w_shift_next;
    logic          w_ready_next;
    logic          w_cs_next;
    logic          w_sck_next;
    logic          w_sdi_next;
    logic          w_done_next;
    logic          w_half_end;

    assign w_half_end = (r_half == HALF_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_half  <= '0;
            r_phase <= 1'b0;
            r_bit   <= 4'd0;
            r_gap   <= '0;
            r_shift <= 16'd0;
            r_ready <= 1'b1;
            r_cs    <= 1'b1;
            r_sck   <= 1'b1;
            r_sdi   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_half  <= w_half_next;
            r_phase <= w_phase_next;
            r_bit   <= w_bit_next;
            r_gap   <= w_gap_next;
            r_shift <= w_shift_next;
            r_ready <= w_ready_next;
            r_cs    <= w_cs_next;
            r_sck   <= w_sck_next;
            r_sdi   <= w_sdi_next;
            r_done  <= w_done_next;
        end
    end

    // r_phase: 0 = sck high half, 1 = sck low half of the current bit
    always_comb begin
        w_state_next = r_state;
        w_half_next  = r_half;
        w_phase_next = r_phase;
        w_bit_next   = r_bit;
        w_gap_next   = r_gap;
        w_shift_next = r_shift;
        case (r_state)
            S_IDLE: begin
                if (valid && r_ready) begin
                    w_state_next = S_SHIFT;
                    w_shift_next = value;
                    w_half_next  = '0;
                    w_phase_next = 1'b0;
                    w_bit_next   = 4'd15;
                end
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_half_next = '0;
                    if (!r_phase) begin
                        w_phase_next = 1'b1;
                    end else begin
                        w_phase_next = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_state_next = S_GAP;
                            w_gap_next   = '0;
                            w_shift_next = 16'd0;
                        end else begin
                            w_bit_next   = r_bit - 4'd1;
                            w_shift_next = {r_shift[14:0], 1'b0};
                        end
                    end
                end else begin
                    w_half_next = r_half + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_next = S_IDLE;
                    w_gap_next   = '0;
                end else begin
                    w_gap_next = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered images of the upcoming state, so they change on the same edge
    always_comb begin
        w_ready_next = (w_state_next == S_IDLE);
        w_cs_next    = (w_state_next != S_SHIFT);
        w_sck_next   = !((w_state_next == S_SHIFT) && w_phase_next);
        w_sdi_next   = (w_state_next == S_SHIFT) ? w_shift_next[15] : 1'b0;
        w_done_next  = (r_state == S_SHIFT) && (w_state_next == S_GAP);
    end

    assign ready = r_ready;
    assign cs    = r_cs;
    assign sck   = r_sck;
    assign sdi   = r_sdi;
    assign done  = r_done;

endmodule
